// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the basic processor.
// Sequences FETCH/DECODE/EXEC/MEM/WB for the 3-bit opcode set, handshakes
// with a variable-latency data memory (with timeout), and counts retired
// instructions with a saturating counter.
module multicycle_ctrl #(
    parameter int unsigned IW          = 9,
    parameter int unsigned CW          = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic [IW-1:0] instr,
    input  logic          alu_zero,
    input  logic          mem_ack,
    output logic          ir_load,
    output logic          pc_inc,
    output logic          pc_branch,
    output logic [2:0]    alu_op,
    output logic          reg_we,
    output logic          mem_req,
    output logic          mem_we,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] instr_count
);

    // Timeout counter must hold values up to MEM_TIMEOUT.
    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

    // Opcode map; 111 is unassigned and treated as HALT.
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_LSH  = 3'b001;
    localparam logic [2:0] OP_RSH  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BNE  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // FSM state encoding.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    // Elaboration-time guard: a zero timeout would make MEM meaningless.
    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("multicycle_ctrl: MEM_TIMEOUT must be at least 1");
    end

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [2:0]    ir_op;
    logic [TW-1:0] tmo_cnt;
    logic          is_alu_op;
    logic          is_mem_op;
    logic          tmo_last;
    logic          retire;

    // Only the opcode field of the instruction matters to the controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[IW-4:0];

    // Opcode class decode of the held IR.
    assign is_alu_op = (ir_op == OP_AND) || (ir_op == OP_LSH) ||
                       (ir_op == OP_RSH) || (ir_op == OP_XOR);
    assign is_mem_op = (ir_op == OP_LD) || (ir_op == OP_SW);

    // True in the MEM cycle that would be the MEM_TIMEOUT-th without an ack.
    assign tmo_last  = (tmo_cnt == TW'(MEM_TIMEOUT - 1));

    // An instruction retires whenever the PC moves.
    assign retire    = pc_inc || pc_branch;

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode from state, IR opcode, alu_zero, mem_ack.
    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        alu_op     = 3'b000;
        reg_we     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                ir_load    = 1'b1;
                state_next = S_DECODE;
            end

            S_DECODE: begin
                if (ir_op == OP_HALT) begin
                    state_next = S_HALT;
                end else if (is_mem_op) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                state_next = S_FETCH;
                if (ir_op == OP_BNE) begin
                    // Branch taken when operands differ (result non-zero).
                    alu_op = OP_BNE;
                    if (!alu_zero) begin
                        pc_branch = 1'b1;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end else if (is_alu_op) begin
                    alu_op = ir_op;
                    reg_we = 1'b1;
                    pc_inc = 1'b1;
                end
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (ir_op == OP_SW);
                if (mem_ack) begin
                    // A store completes here; a load still needs writeback.
                    if (ir_op == OP_SW) begin
                        pc_inc     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (tmo_last) begin
                    state_next = S_ERR;
                end
            end

            S_WB: begin
                reg_we     = 1'b1;
                pc_inc     = 1'b1;
                state_next = S_FETCH;
            end

            S_HALT: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end

            S_ERR: begin
                // Sticky until reset.
                err = 1'b1;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Instruction register: captures the opcode during FETCH.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ir_op <= 3'b000;
        end else if (ir_load) begin
            ir_op <= instr[IW-1 -: 3];
        end
    end

    // Memory timeout counter: cleared on entry to MEM, counts no-ack cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tmo_cnt <= '0;
        end else if (state == S_DECODE) begin
            tmo_cnt <= '0;
        end else if ((state == S_MEM) && !mem_ack) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Retired-instruction counter: cleared on start, saturates at all-ones.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            instr_count <= '0;
        end else if ((state == S_IDLE) && start) begin
            instr_count <= '0;
        end else if (retire && (instr_count != {CW{1'b1}})) begin
            instr_count <= instr_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a program-level reference model
// predicts each retirement / halt / error event (cycle, enables, count);
// a monitor pops and compares whenever the DUT presents such an event.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam int IW     = 9;
    localparam int CW     = 6;
    localparam int MEM_TO = 15;
    localparam int ROM_N  = 128;
    localparam int NEVER  = 1000;
    localparam int CMAX   = (1 << CW) - 1;

    logic          Clk;
    logic          Reset_n;
    logic          start;
    logic [IW-1:0] instr;
    logic          alu_zero;
    logic          mem_ack;
    logic          ir_load;
    logic          pc_inc;
    logic          pc_branch;
    logic [2:0]    alu_op;
    logic          reg_we;
    logic          mem_req;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          err;
    logic [CW-1:0] instr_count;

    // Program ROM by PC; branch outcome and memory waits by execution index.
    logic [IW-1:0] rom [ROM_N];
    bit            zero_tab [ROM_N];
    int            wait_tab [ROM_N];

    logic [6:0] tb_pc;
    logic [6:0] fetch_n;
    logic [6:0] cur;
    int         wcnt;
    logic       noise_ack;

    int vectors;
    int miscompares;

    typedef struct {
        int cyc;
        bit pc_inc;
        bit pc_branch;
        bit reg_we;
        bit done;
        bit err;
        int alu_op;
        int mem_cycles;
        int mem_we_cycles;
        int cnt;
    } exp_t;

    exp_t sb[$];

    multicycle_ctrl #(
        .IW(IW),
        .CW(CW),
        .MEM_TIMEOUT(MEM_TO)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .start(start),
        .instr(instr),
        .alu_zero(alu_zero),
        .mem_ack(mem_ack),
        .ir_load(ir_load),
        .pc_inc(pc_inc),
        .pc_branch(pc_branch),
        .alu_op(alu_op),
        .reg_we(reg_we),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .busy(busy),
        .done(done),
        .err(err),
        .instr_count(instr_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Environment: ROM, PC, per-instruction alu_zero, memory with programmed waits.
    assign instr    = rom[tb_pc];
    assign alu_zero = zero_tab[cur];
    assign mem_ack  = mem_req ? (wcnt == wait_tab[cur]) : noise_ack;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tb_pc   <= '0;
            fetch_n <= '0;
            cur     <= '0;
            wcnt    <= 0;
        end else begin
            if (!busy) begin
                tb_pc   <= '0;
                fetch_n <= '0;
            end else begin
                if (pc_inc) tb_pc <= tb_pc + 7'd1;
                else if (pc_branch) tb_pc <= tb_pc + 7'd2;
                if (ir_load) begin
                    cur     <= fetch_n;
                    fetch_n <= fetch_n + 7'd1;
                end
            end
            wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
        end
    end

    // Random mem_ack chatter whenever no request is outstanding.
    always @(negedge Clk) noise_ack <= 1'($urandom);

    function automatic void chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= CMAX) ? c : c + 1;
    endfunction

    // Reference model: walk the program with the latency rules, push events.
    task automatic model_push(output int final_cnt, output bit to_err);
        int pc;
        int t;
        int cnt;
        int k;
        int w;
        bit fin;
        logic [2:0] op;
        exp_t e;
        pc = 0; t = 0; cnt = 0; k = 0; fin = 0; to_err = 0;
        while (!fin) begin
            op = rom[pc][IW-1 -: 3];
            w  = wait_tab[k];
            e  = '{default: 0};
            e.cnt = cnt;
            case (op)
                3'd4, 3'd5: begin
                    if (w >= MEM_TO) begin
                        e.cyc           = t + 3 + MEM_TO;
                        e.err           = 1;
                        e.mem_cycles    = MEM_TO;
                        e.mem_we_cycles = (op == 3'd5) ? MEM_TO : 0;
                        to_err          = 1;
                        fin             = 1;
                    end else if (op == 3'd4) begin
                        t += 4 + w;
                        e.cyc        = t;
                        e.pc_inc     = 1;
                        e.reg_we     = 1;
                        e.mem_cycles = w + 1;
                        cnt = sat_inc(cnt);
                        pc++;
                    end else begin
                        t += 3 + w;
                        e.cyc           = t;
                        e.pc_inc        = 1;
                        e.mem_cycles    = w + 1;
                        e.mem_we_cycles = w + 1;
                        cnt = sat_inc(cnt);
                        pc++;
                    end
                end
                3'd6: begin
                    t += 3;
                    e.cyc    = t;
                    e.alu_op = 6;
                    if (zero_tab[k]) begin
                        e.pc_inc = 1;
                        pc += 1;
                    end else begin
                        e.pc_branch = 1;
                        pc += 2;
                    end
                    cnt = sat_inc(cnt);
                end
                3'd7: begin
                    t += 3;
                    e.cyc  = t;
                    e.done = 1;
                    fin    = 1;
                end
                default: begin
                    t += 3;
                    e.cyc    = t;
                    e.pc_inc = 1;
                    e.reg_we = 1;
                    e.alu_op = int'(op);
                    cnt = sat_inc(cnt);
                    pc++;
                end
            endcase
            sb.push_back(e);
            k++;
        end
        final_cnt = cnt;
    endtask

    // Monitor: per-cycle invariants, and event comparison against the scoreboard.
    int   cyc;
    int   mcyc;
    int   mwcyc;
    bit   err_seen;
    exp_t got;

    initial begin
        cyc = 0; mcyc = 0; mwcyc = 0; err_seen = 0;
        forever begin
            @(negedge Clk);
            if (!Reset_n) begin
                cyc = 0; mcyc = 0; mwcyc = 0; err_seen = 0;
            end else if (!busy) begin
                cyc = 0; mcyc = 0; mwcyc = 0;
            end else begin
                cyc++;
                if (mem_req) mcyc++;
                if (mem_we) mwcyc++;
                chk("excl_pcinc_pcbranch", int'(pc_inc && pc_branch), 0);
                chk("excl_memreq_regwe", int'(mem_req && reg_we), 0);
                if (pc_inc || pc_branch || done || (err && !err_seen)) begin
                    if (err) err_seen = 1;
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_event: got event at cycle %0d, expected none", cyc);
                    end else begin
                        got = sb.pop_front();
                        chk("ev_cycle", cyc, got.cyc);
                        chk("ev_pc_inc", int'(pc_inc), int'(got.pc_inc));
                        chk("ev_pc_branch", int'(pc_branch), int'(got.pc_branch));
                        chk("ev_reg_we", int'(reg_we), int'(got.reg_we));
                        chk("ev_done", int'(done), int'(got.done));
                        chk("ev_err", int'(err), int'(got.err));
                        chk("ev_alu_op", int'(alu_op), got.alu_op);
                        chk("ev_mem_req_cycles", mcyc, got.mem_cycles);
                        chk("ev_mem_we_cycles", mwcyc, got.mem_we_cycles);
                        chk("ev_instr_count", int'(instr_count), got.cnt);
                    end
                    mcyc = 0;
                    mwcyc = 0;
                end
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < ROM_N; i++) begin
            rom[i]      = {3'b111, 6'($urandom)};
            zero_tab[i] = 1'($urandom);
            wait_tab[i] = 0;
        end
    endtask

    task automatic set_ins(input int pc, input logic [2:0] op);
        rom[pc] = {op, 6'($urandom)};
    endtask

    // Run a program that ends in HALT; start is chattered while busy.
    task automatic run_prog(input string name);
        int fcnt;
        bit to_err;
        int lim;
        model_push(fcnt, to_err);
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        lim = 0;
        while (busy && lim < 3000) begin
            @(negedge Clk);
            start = busy && !done && ($urandom % 3 == 0);
            lim++;
        end
        start = 1'b0;
        if (lim >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: busy still %0d after %0d cycles, required 0", name, busy, lim);
        end
        chk({name, "_busy_after"}, int'(busy), 0);
        chk({name, "_final_count"}, int'(instr_count), fcnt);
        chk({name, "_events_left"}, sb.size(), 0);
    endtask

    initial begin
        int lim;
        int mc;
        int fcnt;
        bit to_err;
        int len;
        vectors = 0;
        miscompares = 0;
        Reset_n = 1'b0;
        start   = 1'b0;
        clear_prog();
        repeat (3) @(negedge Clk);

        // Reset state.
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ir_load", int'(ir_load), 0);
        chk("rst_count", int'(instr_count), 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("idle_busy", int'(busy), 0);

        // XOR, AND, HALT.
        clear_prog();
        set_ins(0, 3'b011);
        set_ins(1, 3'b000);
        run_prog("xor_and_halt");

        // BNE taken then not taken.
        clear_prog();
        set_ins(0, 3'b110); zero_tab[0] = 1'b0;
        set_ins(1, 3'b000);
        set_ins(2, 3'b110); zero_tab[1] = 1'b1;
        run_prog("bne_pair");

        // LD with 3 waits, SW zero-wait.
        clear_prog();
        set_ins(0, 3'b100); wait_tab[0] = 3;
        set_ins(1, 3'b101); wait_tab[1] = 0;
        run_prog("ld_sw");

        // Ack on the last allowed MEM cycle still completes.
        clear_prog();
        set_ins(0, 3'b100); wait_tab[0] = MEM_TO - 1;
        set_ins(1, 3'b101); wait_tab[1] = MEM_TO - 1;
        set_ins(2, 3'b001);
        run_prog("ack_at_limit");

        // Random programs.
        for (int r = 0; r < 8; r++) begin
            clear_prog();
            len = int'($urandom_range(4, 20));
            for (int i = 0; i < len; i++) begin
                set_ins(i, 3'($urandom % 7));
                wait_tab[i] = int'($urandom % 5);
            end
            run_prog("random");
        end

        // Counter saturation.
        clear_prog();
        for (int i = 0; i < 70; i++) begin
            set_ins(i, 3'($urandom % 6));
            wait_tab[i] = int'($urandom % 3);
        end
        run_prog("saturate");

        // SW never acknowledged -> ERR, held, start ignored, reset clears.
        clear_prog();
        set_ins(0, 3'b101); wait_tab[0] = NEVER;
        model_push(fcnt, to_err);
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        lim = 0;
        while (!err && lim < 100) begin
            @(negedge Clk);
            lim++;
        end
        if (lim >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL err_wait: err still %0d after %0d cycles, required 1", err, lim);
        end
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom);
            @(negedge Clk);
            chk("err_held", int'(err), 1);
            chk("err_busy", int'(busy), 1);
            chk("err_no_mem_req", int'(mem_req), 0);
            chk("err_no_pc_inc", int'(pc_inc), 0);
        end
        start = 1'b0;
        chk("err_events_left", sb.size(), 0);
        #2 Reset_n = 1'b0;
        #1;
        chk("err_rst_err", int'(err), 0);
        chk("err_rst_busy", int'(busy), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("err_after_rst_idle", int'(busy), 0);

        // Reset asserted mid-MEM of an LD.
        clear_prog();
        set_ins(0, 3'b011);
        set_ins(1, 3'b100); wait_tab[1] = 10;
        model_push(fcnt, to_err);
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        mc = 0;
        lim = 0;
        while (mc < 3 && lim < 100) begin
            @(negedge Clk);
            if (mem_req) mc++;
            lim++;
        end
        if (lim >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL midmem_wait: saw %0d mem_req cycles, required 3", mc);
        end
        chk("midmem_count_before", int'(instr_count), 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("midmem_mem_req", int'(mem_req), 0);
        chk("midmem_busy", int'(busy), 0);
        chk("midmem_reg_we", int'(reg_we), 0);
        chk("midmem_pc_inc", int'(pc_inc), 0);
        chk("midmem_alu_op", int'(alu_op), 0);
        chk("midmem_count", int'(instr_count), 0);
        sb.delete();
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk("midmem_post_busy", int'(busy), 0);
            chk("midmem_post_reg_we", int'(reg_we), 0);
            chk("midmem_post_count", int'(instr_count), 0);
        end

        // Normal operation after reset.
        clear_prog();
        set_ins(0, 3'b010);
        set_ins(1, 3'b110); zero_tab[1] = 1'b0;
        run_prog("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
